// File: rtl/sam_sequencer.sv
//==============================================================================
// Module      : sam_sequencer
// Description : Microprogrammed control sequencer for the SAM accumulator
//               datapath. Walks fetch / decode / execute for the four-opcode
//               ISA and drives the registered 22-bit control word `b`.
//               Access states (IF_RD, OP_RD, ST_WR) dwell at least two cycles
//               and then hold while WAIT is high.
//               Optional feature macro: SAM_SEQ_WAIT_TIMEOUT_EN
//               (memory wait timeout, FAULT state and sticky `fault` flag).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sam_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WAIT,
    input  logic        ir15,
    input  logic        ir14,
    input  logic        ac15,
    output logic [21:0] b,
    output logic [3:0]  state,
    output logic        fetch,
    output logic        fault
);

    // State codes double as the debug `state` output
    localparam logic [3:0] c_INIT    = 4'd0;
    localparam logic [3:0] c_IF_MAR  = 4'd1;
    localparam logic [3:0] c_IF_RD   = 4'd2;
    localparam logic [3:0] c_IF_CAP  = 4'd3;
    localparam logic [3:0] c_IF_IR   = 4'd4;
    localparam logic [3:0] c_DEC     = 4'd5;
    localparam logic [3:0] c_OP_RD   = 4'd6;
    localparam logic [3:0] c_OP_CAP  = 4'd7;
    localparam logic [3:0] c_EX_ALU  = 4'd8;
    localparam logic [3:0] c_EX_RES  = 4'd9;
    localparam logic [3:0] c_EX_WB   = 4'd10;
    localparam logic [3:0] c_ST_RBUS = 4'd11;
    localparam logic [3:0] c_ST_MBR  = 4'd12;
    localparam logic [3:0] c_ST_WR   = 4'd13;
    localparam logic [3:0] c_BR      = 4'd14;
    localparam logic [3:0] c_FAULT   = 4'd15;

    // Control words, one per state (EX_* split by LOAD / ADD)
    localparam logic [21:0] c_W_INIT    = 22'h000040;
    localparam logic [21:0] c_W_IF_MAR  = 22'h200400;
    localparam logic [21:0] c_W_RD      = 22'h00200C;
    localparam logic [21:0] c_W_CAP     = 22'h002288;
    localparam logic [21:0] c_W_IF_IR   = 22'h080820;
    localparam logic [21:0] c_W_DEC     = 22'h100400;
    localparam logic [21:0] c_W_ALU_LD  = 22'h014000;
    localparam logic [21:0] c_W_ALU_ADD = 22'h038000;
    localparam logic [21:0] c_W_RES_LD  = 22'h014001;
    localparam logic [21:0] c_W_RES_ADD = 22'h038001;
    localparam logic [21:0] c_W_WB_LD   = 22'h054000;
    localparam logic [21:0] c_W_WB_ADD  = 22'h078000;
    localparam logic [21:0] c_W_ST_RBUS = 22'h000002;
    localparam logic [21:0] c_W_ST_MBR  = 22'h000100;
    localparam logic [21:0] c_W_ST_WR   = 22'h003004;
    localparam logic [21:0] c_W_BR      = 22'h100010;
    localparam logic [21:0] c_W_FAULT   = 22'h000000;

    // The timeout counter is 8 bits wide, so the threshold must fit in it
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("sam_sequencer: TIMEOUT_CYCLES must be in 1..255");
    end

    logic [3:0]  state_q, state_d;
    logic [21:0] b_q, b_d;
    logic        fetch_q, fetch_d;
    logic [1:0]  opc_q;
    logic        dwell_q, dwell_d;
    logic        w_access;
    logic        w_exit;
    logic        w_stay;

    assign w_access = (state_q == c_IF_RD) || (state_q == c_OP_RD) || (state_q == c_ST_WR);
    // dwell_q is set once the first cycle of an access state has elapsed
    assign w_exit   = dwell_q && !WAIT;
    assign w_stay   = w_access && (state_d == state_q);
    assign dwell_d  = w_stay;

`ifdef SAM_SEQ_WAIT_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       fault_q;
    logic       w_timeout;

    assign w_timeout = w_access && WAIT && (to_cnt_q == c_TIMEOUT);
    assign to_cnt_d  = w_stay ? (to_cnt_q + {7'd0, WAIT}) : 8'd0;
    assign fault     = fault_q;

    // Wait-cycle counter and sticky fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= 8'd0;
            fault_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            fault_q  <= fault_q | (state_d == c_FAULT);
        end
    end
`else
    logic w_timeout;

    assign w_timeout = 1'b0;
    assign fault     = 1'b0;
`endif

    // State register plus registered Moore outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_INIT;
            b_q     <= c_W_INIT;
            fetch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            fetch_q <= fetch_d;
        end
    end

    // Opcode latch (only at DEC) and access-state dwell flag
    always_ff @(posedge clk) begin
        if (reset) begin
            opc_q   <= 2'b00;
            dwell_q <= 1'b0;
        end else begin
            if (state_q == c_DEC) begin
                opc_q <= {ir15, ir14};
            end
            dwell_q <= dwell_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_INIT:    state_d = c_IF_MAR;
            c_IF_MAR:  state_d = c_IF_RD;
            c_IF_RD:   if (w_exit) state_d = c_IF_CAP;
            c_IF_CAP:  state_d = c_IF_IR;
            c_IF_IR:   state_d = c_DEC;
            c_DEC: begin
                case ({ir15, ir14})
                    2'b00,
                    2'b01:   state_d = c_OP_RD;
                    2'b10:   state_d = c_ST_RBUS;
                    default: state_d = ac15 ? c_BR : c_IF_MAR;
                endcase
            end
            c_OP_RD:   if (w_exit) state_d = c_OP_CAP;
            c_OP_CAP:  state_d = c_EX_ALU;
            c_EX_ALU:  state_d = c_EX_RES;
            c_EX_RES:  state_d = c_EX_WB;
            c_EX_WB:   state_d = c_IF_MAR;
            c_ST_RBUS: state_d = c_ST_MBR;
            c_ST_MBR:  state_d = c_ST_WR;
            c_ST_WR:   if (w_exit) state_d = c_IF_MAR;
            c_BR:      state_d = c_IF_MAR;
            default:   state_d = c_FAULT;
        endcase
        // A stuck memory overrides the normal access-state exit
        if (w_timeout) begin
            state_d = c_FAULT;
        end
    end

    // Output logic: word of the state being entered
    always_comb begin
        b_d     = c_W_FAULT;
        fetch_d = (state_d == c_IF_MAR);
        case (state_d)
            c_INIT:    b_d = c_W_INIT;
            c_IF_MAR:  b_d = c_W_IF_MAR;
            c_IF_RD:   b_d = c_W_RD;
            c_IF_CAP:  b_d = c_W_CAP;
            c_IF_IR:   b_d = c_W_IF_IR;
            c_DEC:     b_d = c_W_DEC;
            c_OP_RD:   b_d = c_W_RD;
            c_OP_CAP:  b_d = c_W_CAP;
            c_EX_ALU:  b_d = opc_q[0] ? c_W_ALU_ADD : c_W_ALU_LD;
            c_EX_RES:  b_d = opc_q[0] ? c_W_RES_ADD : c_W_RES_LD;
            c_EX_WB:   b_d = opc_q[0] ? c_W_WB_ADD  : c_W_WB_LD;
            c_ST_RBUS: b_d = c_W_ST_RBUS;
            c_ST_MBR:  b_d = c_W_ST_MBR;
            c_ST_WR:   b_d = c_W_ST_WR;
            c_BR:      b_d = c_W_BR;
            default:   b_d = c_W_FAULT;
        endcase
    end

    assign b     = b_q;
    assign state = state_q;
    assign fetch = fetch_q;

endmodule

`default_nettype wire

// File: tb/tb_sam_sequencer.sv
//==============================================================================
// Module      : tb_sam_sequencer
// Description : Self-checking bench for sam_sequencer. Each instruction is
//               expanded into an expected per-cycle trace of (state, word)
//               built from the instruction-level rules, and instruction
//               latency is checked against base latency plus extra waits.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sam_sequencer;

    logic        clk = 1'b0;
    logic        reset, WAIT, ir15, ir14, ac15;
    logic [21:0] b;
    logic [3:0]  state;
    logic        fetch, fault;

    int errors = 0;
    int checks = 0;
    bit force_junk = 1'b0;

    always #5 clk = ~clk;

    sam_sequencer #(.TIMEOUT_CYCLES(255)) dut (
        .clk   (clk),
        .reset (reset),
        .WAIT  (WAIT),
        .ir15  (ir15),
        .ir14  (ir14),
        .ac15  (ac15),
        .b     (b),
        .state (state),
        .fetch (fetch),
        .fault (fault)
    );

    // One expected cycle: state/word, how WAIT is driven, and whether it is DEC
    typedef struct {
        logic [3:0]  st;
        logic [21:0] w;
        bit          free;
        bit          wv;
        bit          dec;
    } cyc_t;

    cyc_t tr[$];

    // One directed instruction vector with its expected latency
    typedef struct {
        int op;
        bit ac;
        int eif;
        int eop;
        int est;
        bit junk;
        int lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word table straight from the control-word list
    function automatic logic [21:0] word_of(input int st, input int op);
        case (st)
            0:  return 22'h000040;
            1:  return 22'h200400;
            2:  return 22'h00200C;
            3:  return 22'h002288;
            4:  return 22'h080820;
            5:  return 22'h100400;
            6:  return 22'h00200C;
            7:  return 22'h002288;
            8:  return (op == 1) ? 22'h038000 : 22'h014000;
            9:  return (op == 1) ? 22'h038001 : 22'h014001;
            10: return (op == 1) ? 22'h078000 : 22'h054000;
            11: return 22'h000002;
            12: return 22'h000100;
            13: return 22'h003004;
            14: return 22'h100010;
            default: return 22'h000000;
        endcase
    endfunction

    // Append one state: access states take 2+extra cycles, WAIT high on cycles 2..extra+1
    task automatic add_state(input int st, input int op, input bit acc, input int extra, input bit dec);
        cyc_t c;
        int n;
        n = acc ? (2 + extra) : 1;
        for (int j = 0; j < n; j++) begin
            c.st   = 4'(st);
            c.w    = word_of(st, op);
            c.free = !acc || (j == 0);
            c.wv   = acc && (j >= 1) && (j <= extra);
            c.dec  = dec;
            tr.push_back(c);
        end
    endtask

    task automatic build(input int op, input bit ac, input int eif, input int eop, input int est);
        tr.delete();
        add_state(1, op, 0, 0, 0);
        add_state(2, op, 1, eif, 0);
        add_state(3, op, 0, 0, 0);
        add_state(4, op, 0, 0, 0);
        add_state(5, op, 0, 0, 1);
        if (op < 2) begin
            add_state(6, op, 1, eop, 0);
            add_state(7, op, 0, 0, 0);
            add_state(8, op, 0, 0, 0);
            add_state(9, op, 0, 0, 0);
            add_state(10, op, 0, 0, 0);
        end else if (op == 2) begin
            add_state(11, op, 0, 0, 0);
            add_state(12, op, 0, 0, 0);
            add_state(13, op, 1, est, 0);
        end else if (ac) begin
            add_state(14, op, 0, 0, 0);
        end
    endtask

    task automatic drive_junk(input int op);
        logic [1:0] o;
        o = 2'(op);
        if (force_junk) {ir15, ir14} = ~o;
        else            {ir15, ir14} = 2'($urandom_range(0, 3));
        ac15 = 1'($urandom_range(0, 1));
    endtask

    // Runs one instruction from the current IF_MAR cycle (sampled #1 after posedge).
    // stop_at > 0 abandons the instruction after that many cycles.
    task automatic run_instr(input int op, input bit ac, input int eif, input int eop,
                             input int est, input int exp_lat, input int stop_at);
        int k;
        logic [1:0] o;
        o = 2'(op);
        build(op, ac, eif, eop, est);
        k = 0;
        forever begin
            if (k < tr.size()) begin
                check("state", 32'(state), 32'(tr[k].st));
                check("b", 32'(b), 32'(tr[k].w));
                check("fetch", 32'(fetch), 32'(k == 0));
                WAIT = tr[k].free ? 1'($urandom_range(0, 1)) : tr[k].wv;
                if (tr[k].dec) {ir15, ir14, ac15} = {o, ac};
                else           drive_junk(op);
            end else begin
                WAIT = 1'b0;
                drive_junk(op);
            end
            @(posedge clk); #1;
            k++;
            if (stop_at > 0 && k == stop_at) return;
            if (fetch === 1'b1 || k >= 80) break;
        end
        check("latency", 32'(k), 32'(exp_lat));
    endtask

    task automatic check_reset_state();
        check("rst_state", 32'(state), 32'd0);
        check("rst_b", 32'(b), 32'h000040);
        check("rst_fetch", 32'(fetch), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int op, eif, eop, est, lat, n;
        bit ac;

        vecs[0] = '{op: 0, ac: 0, eif: 0, eop: 0, est: 0, junk: 0, lat: 12}; // LOAD
        vecs[1] = '{op: 1, ac: 0, eif: 0, eop: 0, est: 0, junk: 0, lat: 12}; // ADD
        vecs[2] = '{op: 2, ac: 0, eif: 0, eop: 0, est: 4, junk: 0, lat: 14}; // STORE, 4 waits
        vecs[3] = '{op: 3, ac: 1, eif: 0, eop: 0, est: 0, junk: 0, lat: 7};  // BRN taken
        vecs[4] = '{op: 3, ac: 0, eif: 0, eop: 0, est: 0, junk: 0, lat: 6};  // BRN not taken
        vecs[5] = '{op: 1, ac: 0, eif: 2, eop: 3, est: 0, junk: 0, lat: 17}; // ADD with waits
        vecs[6] = '{op: 1, ac: 1, eif: 0, eop: 0, est: 0, junk: 1, lat: 12}; // ADD, opcode flipped
        vecs[7] = '{op: 2, ac: 1, eif: 0, eop: 0, est: 0, junk: 0, lat: 10}; // STORE
        vecs[8] = '{op: 0, ac: 1, eif: 1, eop: 0, est: 0, junk: 1, lat: 13}; // LOAD, 1 fetch wait

        reset = 1'b1; WAIT = 1'b0; ir15 = 1'b0; ir14 = 1'b0; ac15 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            force_junk = vecs[i].junk;
            run_instr(vecs[i].op, vecs[i].ac, vecs[i].eif, vecs[i].eop, vecs[i].est,
                      vecs[i].lat, 0);
        end
        force_junk = 1'b0;

        // Reset for 3 cycles in the middle of an ADD
        run_instr(1, 0, 0, 0, 0, 0, 9);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_reset_state();
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Randomised instruction stream
        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 3);
            ac  = 1'($urandom_range(0, 1));
            eif = $urandom_range(0, 3);
            eop = $urandom_range(0, 3);
            est = $urandom_range(0, 3);
            case (op)
                0, 1:    lat = 12 + eif + eop;
                2:       lat = 10 + eif + est;
                default: lat = (ac ? 7 : 6) + eif;
            endcase
            run_instr(op, ac, eif, eop, est, lat, 0);
        end

        // WAIT stuck high in IF_RD
        WAIT = 1'b1;
        @(posedge clk); #1;
        check("stuck_enter", 32'(state), 32'd2);
`ifdef SAM_SEQ_WAIT_TIMEOUT_EN
        n = 0;
        while (state == 4'd2 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd256);
        check("fault_state", 32'(state), 32'd15);
        check("fault_b", 32'(b), 32'd0);
        check("fault_flag", 32'(fault), 32'd1);
        WAIT = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fault_hold", 32'(state), 32'd15);
        check("fault_sticky", 32'(fault), 32'd1);
`else
        n = 0;
        repeat (1000) @(posedge clk);
        #1;
        check("stuck_state", 32'(state), 32'd2);
        check("stuck_b", 32'(b), 32'h00200C);
        check("stuck_fault", 32'(fault), 32'd0);
        WAIT = 1'b0;
        @(posedge clk); #1;
        check("stuck_release", 32'(state), 32'd3);
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_state();
        reset = 1'b0;
        @(posedge clk); #1;
        check("after_reset", 32'(state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
